// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MDS_IDLE = 3'd0,
    MDS_PREP = 3'd1,
    MDS_CALC = 3'd2,
    MDS_FIX  = 3'd3,
    MDS_DONE = 3'd4
  } md_state_e;

  // MUL is handled as unsigned: the low half of the product is sign-independent.
  function automatic logic md_signed_a(input logic [2:0] f3);
    case (f3)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: md_signed_a = 1'b1;
      default:                            md_signed_a = 1'b0;
    endcase
  endfunction

  function automatic logic md_signed_b(input logic [2:0] f3);
    case (f3)
      MD_MULH, MD_DIV, MD_REM: md_signed_b = 1'b1;
      default:                 md_signed_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration on a shared XLEN+1-bit adder: conditional add and
// right shift for multiply, or left shift and trial subtract for restoring divide.
module muldiv_seq_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] w_add_a;
  logic [XLEN:0] w_add_b;
  logic [XLEN:0] w_sum;
  logic          w_cout;

  // Subtract is a + ~b + 1; carry-out set means no borrow.
  always_comb begin
    if (is_div_i) begin
      w_add_a = {hi_i, lo_i[XLEN-1]};
      w_add_b = ~{1'b0, opnd_i};
    end else begin
      w_add_a = {1'b0, hi_i};
      w_add_b = {1'b0, opnd_i};
    end
  end

  assign {w_cout, w_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, is_div_i};

  always_comb begin
    if (is_div_i) begin
      hi_o = w_cout ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], w_cout};
    end else if (lo_i[0]) begin
      hi_o = w_sum[XLEN:1];
      lo_o = {w_sum[0], lo_i[XLEN-1:1]};
    end else begin
      hi_o = {1'b0, hi_i[XLEN-1:1]};
      lo_o = {hi_i[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes, iterated
// XLEN times through muldiv_seq_step, then sign-fixed; div-by-zero and overflow exit early.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  md_state_e          r_state;
  logic [2:0]         r_funct3;
  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;
  logic [XLEN-1:0]    r_opnd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [XLEN-1:0]    r_result;

  logic               w_is_div;
  logic               w_sgn_a;
  logic               w_sgn_b;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic               w_div0;
  logic               w_ovf;
  logic               w_early;
  logic [XLEN-1:0]    w_early_res;
  logic [XLEN-1:0]    w_step_hi;
  logic [XLEN-1:0]    w_step_lo;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_quo;
  logic [XLEN-1:0]    w_rem;
  logic [XLEN-1:0]    w_fix_res;

  // In PREP, r_lo/r_opnd still hold the raw rs1/rs2 values latched in IDLE.
  assign w_is_div = r_funct3[2];
  assign w_sgn_a  = md_signed_a(r_funct3) & r_lo[XLEN-1];
  assign w_sgn_b  = md_signed_b(r_funct3) & r_opnd[XLEN-1];
  assign w_mag_a  = w_sgn_a ? (~r_lo + XLEN'(1)) : r_lo;
  assign w_mag_b  = w_sgn_b ? (~r_opnd + XLEN'(1)) : r_opnd;
  assign w_div0   = (r_opnd == {XLEN{1'b0}});
  assign w_ovf    = md_signed_a(r_funct3) && (r_lo == {1'b1, {(XLEN-1){1'b0}}})
                    && (r_opnd == {XLEN{1'b1}});
  assign w_early  = w_is_div & (w_div0 | w_ovf);

  // Early-out results for divide by zero and signed overflow.
  always_comb begin
    if (w_div0) begin
      w_early_res = r_funct3[1] ? r_lo : {XLEN{1'b1}};
    end else if (w_ovf) begin
      w_early_res = r_funct3[1] ? {XLEN{1'b0}} : r_lo;
    end else begin
      w_early_res = {XLEN{1'b0}};
    end
  end

  muldiv_seq_step #(.XLEN(XLEN)) u_step (
    .is_div_i (w_is_div),
    .hi_i     (r_hi),
    .lo_i     (r_lo),
    .opnd_i   (r_opnd),
    .hi_o     (w_step_hi),
    .lo_o     (w_step_lo)
  );

  // Sign fix: products negate as a double-width value, quotient/remainder individually.
  assign w_prod = r_neg ? (~{r_hi, r_lo} + (2*XLEN)'(1)) : {r_hi, r_lo};
  assign w_quo  = r_neg ? (~r_lo + XLEN'(1)) : r_lo;
  assign w_rem  = r_neg ? (~r_hi + XLEN'(1)) : r_hi;

  always_comb begin
    case (r_funct3)
      MD_MUL:                        w_fix_res = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               w_fix_res = w_quo;
      MD_REM, MD_REMU:               w_fix_res = w_rem;
      default:                       w_fix_res = {XLEN{1'b0}};
    endcase
  end

  // Control FSM with registered busy/done/result; flush overrides every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= MDS_IDLE;
      r_funct3 <= 3'b000;
      r_hi     <= {XLEN{1'b0}};
      r_lo     <= {XLEN{1'b0}};
      r_opnd   <= {XLEN{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_state <= MDS_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          MDS_IDLE: begin
            if (start_i) begin
              r_funct3 <= funct3_i;
              r_lo     <= op_a_i;
              r_opnd   <= op_b_i;
              r_state  <= MDS_PREP;
              r_busy   <= 1'b1;
            end
          end
          MDS_PREP: begin
            if (w_early) begin
              r_result <= w_early_res;
              r_done   <= 1'b1;
              r_state  <= MDS_DONE;
            end else begin
              r_hi    <= {XLEN{1'b0}};
              r_lo    <= w_mag_a;
              r_opnd  <= w_mag_b;
              r_neg   <= (w_is_div && r_funct3[1]) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
              r_cnt   <= CNT_W'(XLEN-1);
              r_state <= MDS_CALC;
            end
          end
          MDS_CALC: begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == {CNT_W{1'b0}}) begin
              r_state <= MDS_FIX;
            end
          end
          MDS_FIX: begin
            r_result <= w_fix_res;
            r_done   <= 1'b1;
            r_state  <= MDS_DONE;
          end
          MDS_DONE: begin
            r_state <= MDS_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= MDS_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: results, latencies, early-outs, flush,
// start-while-busy, back-to-back issue and asynchronous reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one op at the next negedge (cycle 0) and wait for done_o with a bound.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold, output int done_cyc);
    int  lat;
    bit  busy_ok;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    lat = -1; busy_ok = 1'b1; done_cyc = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(negedge clk);
      if (hold) begin
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = n;
        done_cyc = cyc;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_val({tag, "_res"}, result, exp);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    int t1, t2, dc;
    logic [31:0] prev;
    bit seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0, dc);
    @(negedge clk);
    check_val("done_pulse", {31'd0, done}, 32'd0);
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35, 1'b0, dc);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0, dc);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b0, dc);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0, dc);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0, dc);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b0, dc);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 35, 1'b0, dc);
    run_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0, dc);
    run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 2, 1'b0, dc);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0, dc);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0, dc);

    // Flush mid-divide: no done_o, result_o keeps the REM result (0).
    @(negedge clk);
    prev = 32'h0000_0000;
    start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flush_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("flush_no_done", {31'd0, seen}, 32'd0);
    check_val("flush_result", result, prev);

    // Flush together with start in IDLE: not accepted.
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("flush_start_busy", {31'd0, busy}, 32'd0);

    run_op("mul_hold", 3'b000, 32'd3, 32'd4, 32'd12, 35, 1'b1, dc);
    run_op("b2b_1", 3'b000, 32'd3, 32'd4, 32'd12, 35, 1'b0, t1);
    run_op("b2b_2", 3'b000, 32'd5, 32'd6, 32'd30, 35, 1'b0, t2);
    check_val("b2b_gap", t2 - t1, 32'd36);

    // Reset mid-operation at cycle 20.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_done", {31'd0, done}, 32'd0);
    check_val("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 3'b000, 32'd11, 32'd13, 32'd143, 35, 1'b0, dc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
